product_dispenser: RTL and testbench

Output stage of the vending datapath, directly downstream of `vending_machine`. It consumes the one-cycle `dispense` request and queues up to PEND_MAX requests. It drives the spiral motor for a fixed run time, then confirms the drop through the item sensor. It also keeps a saturating stock count, and rejects requests that cannot be served with a one-cycle refund pulse.

---
 rtl/product_dispenser.sv | 154 +++++++++++++++
 tb/tb_product_dispenser.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_dispenser.sv
// product_dispenser: vend request queue, spiral motor timing, drop
// confirmation through the item sensor, and a saturating stock count.
// Requests that cannot be served are answered with a one-cycle refund.
module product_dispenser #(
   parameter int STOCK_W      = 4,
   parameter int INIT_STOCK   = 10,
   parameter int MOTOR_CYCLES = 8,
   parameter int DROP_TIMEOUT = 16,
   parameter int PEND_MAX     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dispense,
   input  logic               item_sensor,
   input  logic               restock,
   input  logic [STOCK_W-1:0] restock_qty,
   output logic               motor_on,
   output logic               vend_done,
   output logic               vend_fail,
   output logic               refund,
   output logic [STOCK_W-1:0] stock,
   output logic [1:0]         pending,
   output logic               empty
);

   // One timer serves both the motor run and the drop wait, so it is
   // sized for whichever interval is longer.
   localparam int TMR_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_DROP
   } state_t;

   state_t             state, state_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic               drop_flag, drop_flag_n;
   logic               launch;
   logic               done_n;
   logic               fail_n;
   logic               accept;
   logic [2:0]         committed;
   logic [1:0]         pending_n;
   logic [STOCK_W-1:0] stock_n;
   logic [STOCK_W:0]   restock_sum;

   // Acceptance: every queued request plus the one in flight must be
   // covered by stock, and the queue must have room.
   always_comb begin
      committed = {1'b0, pending} + {2'b00, (state != IDLE)};
      accept    = dispense
                  && ({29'd0, committed} < {{(32-STOCK_W){1'b0}}, stock})
                  && (pending < 2'(PEND_MAX));
   end

   // Next-state logic for the vend sequence: launch, motor run, drop wait.
   always_comb begin
      state_n     = state;
      timer_n     = timer;
      drop_flag_n = drop_flag;
      launch      = 1'b0;
      done_n      = 1'b0;
      fail_n      = 1'b0;
      unique case (state)
         IDLE: begin
            if (pending != 2'd0) begin
               state_n     = RUN;
               launch      = 1'b1;
               timer_n     = TMR_W'(MOTOR_CYCLES - 1);
               drop_flag_n = 1'b0;
            end
         end
         RUN: begin
            drop_flag_n = drop_flag | item_sensor;
            if (timer == '0) begin
               if (drop_flag_n) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = WAIT_DROP;
                  timer_n = TMR_W'(DROP_TIMEOUT - 1);
               end
            end else begin
               timer_n = timer - 1'b1;
            end
         end
         WAIT_DROP: begin
            if (item_sensor) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (timer == '0) begin
               state_n = IDLE;
               fail_n  = 1'b1;
            end else begin
               timer_n = timer - 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Queue depth and stock bookkeeping; a simultaneous accept and launch
   // cancel out, and restock only counts while the machine is idle.
   always_comb begin
      pending_n = pending;
      if (accept && !launch) begin
         pending_n = pending + 2'd1;
      end else if (!accept && launch) begin
         pending_n = pending - 2'd1;
      end

      restock_sum = {1'b0, stock} + {1'b0, restock_qty};
      stock_n     = stock;
      if (done_n) begin
         if (stock != '0) begin
            stock_n = stock - 1'b1;
         end
      end else if ((state == IDLE) && restock) begin
         stock_n = restock_sum[STOCK_W] ? {STOCK_W{1'b1}} : restock_sum[STOCK_W-1:0];
      end
   end

   // State, counters and registered output pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         drop_flag <= 1'b0;
         pending   <= 2'd0;
         stock     <= STOCK_W'(INIT_STOCK);
         motor_on  <= 1'b0;
         vend_done <= 1'b0;
         vend_fail <= 1'b0;
         refund    <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         drop_flag <= drop_flag_n;
         pending   <= pending_n;
         stock     <= stock_n;
         motor_on  <= (state_n == RUN);
         vend_done <= done_n;
         vend_fail <= fail_n;
         refund    <= dispense && !accept;
      end
   end

   assign empty = (stock == '0);

endmodule

// File: tb/tb_product_dispenser.sv
// Directed testbench for product_dispenser: a default-parameter instance
// plus a single-item instance for the out-of-stock cases.
module tb_product_dispenser;

   logic       clk = 1'b0;
   logic       rst;
   logic       dispense, item_sensor, restock;
   logic [3:0] restock_qty;
   logic       motor_on, vend_done, vend_fail, refund, empty;
   logic [3:0] stock;
   logic [1:0] pending;

   logic       dispense1, item_sensor1;
   logic       motor_on1, vend_done1, vend_fail1, refund1, empty1;
   logic [3:0] stock1;
   logic [1:0] pending1;

   int checkCount = 0;
   int passCount  = 0;

   product_dispenser dut (
      .clk(clk), .rst(rst), .dispense(dispense), .item_sensor(item_sensor),
      .restock(restock), .restock_qty(restock_qty), .motor_on(motor_on),
      .vend_done(vend_done), .vend_fail(vend_fail), .refund(refund),
      .stock(stock), .pending(pending), .empty(empty)
   );

   product_dispenser #(.INIT_STOCK(1)) dut1 (
      .clk(clk), .rst(rst), .dispense(dispense1), .item_sensor(item_sensor1),
      .restock(1'b0), .restock_qty(4'd0), .motor_on(motor_on1),
      .vend_done(vend_done1), .vend_fail(vend_fail1), .refund(refund1),
      .stock(stock1), .pending(pending1), .empty(empty1)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic d, input logic s, input logic r, input logic [3:0] q);
      dispense    = d;
      item_sensor = s;
      restock     = r;
      restock_qty = q;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic waitDone0(input int limit, output logic seen);
      int n = 0;
      while (!vend_done && n < limit) begin
         tick();
         n++;
      end
      seen = vend_done;
   endtask

   task automatic waitDone1(input int limit, output logic seen);
      int n = 0;
      while (!vend_done1 && n < limit) begin
         tick();
         n++;
      end
      seen = vend_done1;
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      int   mc;
      int   bad;
      int   doneCount;
      logic seen;
      logic [1:0] expPend [5];
      logic       expRef  [5];

      rst = 1'b1;
      dispense = 1'b0; item_sensor = 1'b0; restock = 1'b0; restock_qty = 4'd0;
      dispense1 = 1'b0; item_sensor1 = 1'b0;
      tick();
      tick();
      checkOutput("rst_stock", stock, 10);
      checkOutput("rst_pending", pending, 0);
      checkOutput("rst_motor", motor_on, 0);
      checkOutput("rst_pulses", {vend_done, vend_fail, refund}, 0);
      checkOutput("rst_empty", empty, 0);
      checkOutput("rst_stock1", stock1, 1);
      rst = 1'b0;

      $display("[TB] single vend, sensor on RUN cycle 3");
      applyStimulus(1, 0, 0, 0);
      checkOutput("v1_pend_after_accept", pending, 1);
      checkOutput("v1_motor_before_run", motor_on, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("v1_pend_after_launch", pending, 0);
      mc = 0;
      for (int i = 1; i <= 8; i++) begin
         if (motor_on) mc++;
         applyStimulus(0, (i == 3), 0, 0);
      end
      checkOutput("v1_motor_cycles", mc, 8);
      checkOutput("v1_motor_off", motor_on, 0);
      checkOutput("v1_vend_done", vend_done, 1);
      checkOutput("v1_stock", stock, 9);
      applyStimulus(0, 0, 0, 0);
      checkOutput("v1_done_width", vend_done, 0);

      $display("[TB] vend with no sensor, timeout");
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      mc = 0;
      for (int i = 1; i <= 8; i++) begin
         if (motor_on) mc++;
         applyStimulus(0, 0, 0, 0);
      end
      bad = 0;
      for (int i = 1; i <= 16; i++) begin
         if (motor_on || vend_fail || vend_done) bad++;
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("to_motor_cycles", mc, 8);
      checkOutput("to_wait_quiet", bad, 0);
      checkOutput("to_vend_fail", vend_fail, 1);
      checkOutput("to_no_done", vend_done, 0);
      checkOutput("to_stock", stock, 9);
      applyStimulus(0, 0, 0, 0);
      checkOutput("to_fail_width", vend_fail, 0);

      $display("[TB] sensor on WAIT_DROP cycle 4");
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 0);
      checkOutput("wd_still_waiting", {vend_done, vend_fail}, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("wd_vend_done", vend_done, 1);
      checkOutput("wd_no_fail", vend_fail, 0);
      checkOutput("wd_stock", stock, 8);
      applyStimulus(0, 0, 0, 0);

      // The first request launches on the second edge, so four fit before
      // the queue of three is full; the fifth is refunded.
      $display("[TB] five dispense pulses back to back");
      expPend = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
      expRef  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0);
         checkOutput($sformatf("q_pend_%0d", i), pending, expPend[i]);
         checkOutput($sformatf("q_refund_%0d", i), refund, expRef[i]);
      end
      applyStimulus(0, 1, 0, 0);
      checkOutput("q_refund_width", refund, 0);
      doneCount = 0;
      for (int i = 0; i < 50; i++) begin
         if (vend_done) doneCount++;
         applyStimulus(0, 1, 0, 0);
      end
      checkOutput("q_vends", doneCount, 4);
      checkOutput("q_stock", stock, 4);
      checkOutput("q_pend_final", pending, 0);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] restock saturation and restock during RUN");
      applyStimulus(0, 0, 1, 10);
      checkOutput("rs_add", stock, 14);
      applyStimulus(0, 0, 1, 5);
      checkOutput("rs_saturate", stock, 15);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("rs_in_run", motor_on, 1);
      applyStimulus(0, 1, 1, 1);
      checkOutput("rs_ignored", stock, 15);
      restock = 1'b0;
      waitDone0(20, seen);
      checkOutput("rs_vend_seen", seen, 1);
      checkOutput("rs_stock_after", stock, 14);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] reset in RUN with two queued");
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("mr_pend_before", pending, 2);
      checkOutput("mr_motor_before", motor_on, 1);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0);
      checkOutput("mr_motor", motor_on, 0);
      checkOutput("mr_pending", pending, 0);
      checkOutput("mr_stock", stock, 10);
      checkOutput("mr_pulses", {vend_done, vend_fail, refund}, 0);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0);
      checkOutput("mr_stays_idle", {motor_on, pending}, 0);

      $display("[TB] single-item machine");
      dispense1 = 1'b1;
      tick();
      checkOutput("s1_pend", pending1, 1);
      checkOutput("s1_no_refund", refund1, 0);
      tick();
      checkOutput("s1_refund_second", refund1, 1);
      checkOutput("s1_pend_launch", pending1, 0);
      checkOutput("s1_motor", motor_on1, 1);
      dispense1 = 1'b0;
      item_sensor1 = 1'b1;
      waitDone1(20, seen);
      checkOutput("s1_vend_seen", seen, 1);
      checkOutput("s1_stock", stock1, 0);
      checkOutput("s1_empty", empty1, 1);
      item_sensor1 = 1'b0;
      tick();
      dispense1 = 1'b1;
      tick();
      checkOutput("s1_refund_empty", refund1, 1);
      checkOutput("s1_pend_empty", pending1, 0);
      dispense1 = 1'b0;
      tick();
      tick();
      checkOutput("s1_no_motor", motor_on1, 0);
      checkOutput("s1_no_fail", vend_fail1, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
